tick_counter_display: RTL

TICK_COUNTER_DISPLAY -- requirements
Module: tick_counter_display

---
 rtl/tick_counter_display_pkg.sv | 51 +++++
 rtl/tick_counter_display_seg7_decode.sv | 11 +
 rtl/tick_counter_display.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tick_counter_display_pkg.sv
// Shared display definitions: 7-segment encoding table, blank pattern
// and the width/BCD helpers used at elaboration time.
package tick_counter_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bits ordered g..a, active low.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0011000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      4'hF:    return 7'b0001110;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  function automatic logic [31:0] to_bcd(input int value);
    logic [31:0] bcd;
    int rest;
    bcd  = '0;
    rest = value;
    for (int i = 0; i < 8; i++) begin
      bcd[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/tick_counter_display_seg7_decode.sv
// One display digit: a nibble in, active-low segments (g..a) out.
module seg7_decode
  import tick_counter_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_encode(digit_i);

endmodule

// File: rtl/tick_counter_display.sv
// Prescaled up/down modulo counter with wrap pulse, driving a row of
// 7-segment digits as either BCD or hex nibbles.
module tick_counter_display
  import tick_counter_display_pkg::*;
#(
  parameter  int CLK_HZ  = 50_000_000,
  parameter  int TICK_HZ = 30,
  parameter  int MODULUS = 31,
  parameter  int DIGITS  = 2,
  parameter  int DECIMAL = 1,
  localparam int CW      = clog2(MODULUS)
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  down,
  input  logic                  clear,
  output logic                  tick,
  output logic [CW-1:0]         count,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int            DIV        = CLK_HZ / TICK_HZ;
  localparam int            PW         = clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(MODULUS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_counter_display: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (MODULUS < 2) begin : g_bad_modulus
    $error("tick_counter_display: MODULUS must be at least 2");
  end
  if (DECIMAL != 0 && (DIGITS > 8 || (MODULUS - 1) >= 10 ** DIGITS)) begin : g_bad_bcd
    $error("tick_counter_display: MODULUS-1 does not fit in DIGITS decimal digits");
  end
  if (DECIMAL == 0 && CW > 4 * DIGITS) begin : g_bad_hex
    $error("tick_counter_display: MODULUS-1 does not fit in DIGITS hex digits");
  end

  logic [PW-1:0]          prescale_q, prescale_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   wrap_q, wrap_d;
  logic                   atLast, atZero, advance;
  logic [DIGITS-1:0][3:0] digitVal;

  assign tick    = (prescale_q == PRESC_LAST) && !reset;
  assign atLast  = count_q == COUNT_LAST;
  assign atZero  = count_q == '0;
  assign advance = tick && enable;

  // clear wins over a coincident tick and suppresses the wrap pulse.
  always_comb begin
    prescale_d = (prescale_q == PRESC_LAST) ? '0 : prescale_q + 1'b1;
    count_d    = count_q;
    wrap_d     = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (advance) begin
      if (!down) begin
        count_d = atLast ? '0 : count_q + 1'b1;
        wrap_d  = atLast;
      end else begin
        count_d = atZero ? COUNT_LAST : count_q - 1'b1;
        wrap_d  = atZero;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prescale_q <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  if (DECIMAL != 0) begin : g_bcd
    localparam logic [4*DIGITS-1:0] MAX_BCD = (4*DIGITS)'(to_bcd(MODULUS - 1));

    logic [DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic                   carry;

    // Ripple a BCD increment/decrement alongside the binary count so the
    // digits change on the same edge without a binary-to-decimal divider.
    always_comb begin
      bcd_d = bcd_q;
      carry = 1'b0;
      if (clear) begin
        bcd_d = '0;
      end else if (advance) begin
        if (!down && atLast) begin
          bcd_d = '0;
        end else if (down && atZero) begin
          bcd_d = MAX_BCD;
        end else begin
          carry = 1'b1;
          for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
              if (!down) begin
                carry    = bcd_q[i] == 4'd9;
                bcd_d[i] = carry ? 4'd0 : bcd_q[i] + 4'd1;
              end else begin
                carry    = bcd_q[i] == 4'd0;
                bcd_d[i] = carry ? 4'd9 : bcd_q[i] - 4'd1;
              end
            end
          end
        end
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) bcd_q <= '0;
      else       bcd_q <= bcd_d;
    end

    assign digitVal = bcd_q;
  end else begin : g_hex
    logic [4*DIGITS-1:0] countExt;
    assign countExt = (4*DIGITS)'(count_q);
    assign digitVal = countExt;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    seg7_decode u_decode (
      .digit_i (digitVal[i]),
      .seg_o   (HEX[7*i +: 7])
    );
  end

endmodule
